lif_synapse_integrator: RTL



---
 rtl/lif_synapse_integrator.sv | 118 +++++++++++
 1 files changed

// File: rtl/lif_synapse_integrator.sv
`default_nettype none
// ---------------------------------------------------------------------------
// lif_synapse_integrator : weighted spike summation into a saturating 5-bit
// current with periodic decay, for the downstream LIF neuron. Rev 1.0
// ---------------------------------------------------------------------------
module lif_synapse_integrator #(
  parameter int                N_INPUTS     = 4,
  parameter int                DECAY_PERIOD = 4,
  parameter int                DECAY_SHIFT  = 2,
  parameter logic signed [3:0] WEIGHT_INIT  = 4'sd3
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [N_INPUTS-1:0] spike_in,
  input  logic                clear,
  input  logic                wr_en,
  input  logic [1:0]          wr_addr,
  input  logic [3:0]          wr_data,
  output logic [4:0]          current_out,
  output logic                decay_tick,
  output logic [7:0]          event_count
);

  localparam int             CNT_W   = (DECAY_PERIOD > 1) ? $clog2(DECAY_PERIOD) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DECAY_PERIOD - 1);

  logic signed [3:0] weight_q [N_INPUTS];
  logic signed [3:0] weight_d [N_INPUTS];
  logic [CNT_W-1:0]  dcnt_q, dcnt_d;
  logic              decay_tick_q, decay_tick_d;
  logic [4:0]        current_q, current_d;
  logic [7:0]        event_count_q, event_count_d;

  logic signed [6:0] spike_sum;
  logic [4:0]        decay_shifted;
  logic [4:0]        decay_amt;
  logic signed [7:0] next_raw;

  always_comb begin
    for (int i = 0; i < N_INPUTS; i++) begin
      weight_d[i] = weight_q[i];
      if (wr_en && (wr_addr == 2'(i))) begin
        weight_d[i] = wr_data;
      end
    end
  end

  // Spikes always see the pre-edge weights, so a same-cycle write is not visible yet.
  always_comb begin
    spike_sum = 7'sd0;
    for (int i = 0; i < N_INPUTS; i++) begin
      if (spike_in[i]) begin
        spike_sum = spike_sum + {{3{weight_q[i][3]}}, weight_q[i]};
      end
    end
  end

  always_comb begin
    dcnt_d       = (dcnt_q == CNT_MAX) ? '0 : dcnt_q + 1'b1;
    decay_tick_d = (dcnt_q == CNT_MAX);
  end

  always_comb begin
    decay_shifted = current_q >> DECAY_SHIFT;
    decay_amt     = 5'd0;
    if (decay_tick_q && (current_q != 5'd0)) begin
      decay_amt = (decay_shifted == 5'd0) ? 5'd1 : decay_shifted;
    end
    next_raw = $signed({3'b000, current_q}) - $signed({3'b000, decay_amt})
             + {spike_sum[6], spike_sum};
  end

  always_comb begin
    current_d     = current_q;
    event_count_d = event_count_q;
    if (clear) begin
      current_d     = 5'd0;
      event_count_d = 8'd0;
    end else begin
      if (next_raw[7]) begin
        current_d = 5'd0;
      end else if (next_raw > 8'sd31) begin
        current_d = 5'd31;
      end else begin
        current_d = next_raw[4:0];
      end
      if ((|spike_in) && (event_count_q != 8'hFF)) begin
        event_count_d = event_count_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_INPUTS; i++) begin
        weight_q[i] <= WEIGHT_INIT;
      end
      dcnt_q        <= '0;
      decay_tick_q  <= 1'b0;
      current_q     <= 5'd0;
      event_count_q <= 8'd0;
    end else begin
      for (int i = 0; i < N_INPUTS; i++) begin
        weight_q[i] <= weight_d[i];
      end
      dcnt_q        <= dcnt_d;
      decay_tick_q  <= decay_tick_d;
      current_q     <= current_d;
      event_count_q <= event_count_d;
    end
  end

  assign current_out = current_q;
  assign decay_tick  = decay_tick_q;
  assign event_count = event_count_q;

endmodule
`default_nettype wire
